// File: rtl/sprite_pkg.sv
// Shared types and keycode constants for the maze sprite mover.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } state_t;

  localparam logic [7:0] KEY_L = 8'h04;
  localparam logic [7:0] KEY_R = 8'h07;
  localparam logic [7:0] KEY_D = 8'h16;
  localparam logic [7:0] KEY_U = 8'h1A;

endpackage

// File: rtl/key_dir_decode.sv
// Combinational keycode decoder: maps a key/AI command to a direction request.
module key_dir_decode
  import sprite_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       valid,
  output dir_t       dir
);

  always_comb begin
    valid = 1'b1;
    dir   = DIR_UP;
    case (keycode)
      KEY_L:   dir = DIR_LEFT;
      KEY_R:   dir = DIR_RIGHT;
      KEY_D:   dir = DIR_DOWN;
      KEY_U:   dir = DIR_UP;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sprite_mover.sv
// Maze sprite mover: keeps moving until blocked, buffers a pre-pressed turn,
// divides the frame rate for speed, and wraps through the side tunnel.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int W           = 10,
  parameter int X_CENTER    = 202,
  parameter int Y_CENTER    = 253,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 404,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 447,
  parameter int SIZE        = 13,
  parameter int STEP        = 1,
  parameter int SPEED_DIV   = 1,
  parameter int PEND_FRAMES = 16,
  parameter int TUN_Y_LO    = 195,
  parameter int TUN_Y_HI    = 223,
  parameter int TUN_X_LO    = 10,
  parameter int TUN_X_HI    = 390,
  parameter int TUN_L_DEST  = 15,
  parameter int TUN_R_DEST  = 385
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  input  logic [7:0]   keycode,
  input  logic         freeze,
  input  logic         wall_l,
  input  logic         wall_r,
  input  logic         wall_u,
  input  logic         wall_d,
  output logic [W-1:0] pos_x,
  output logic [W-1:0] pos_y,
  output logic [W-1:0] size,
  output dir_t         cur_dir,
  output dir_t         last_dir,
  output logic         moving
);

  localparam int WP1 = W + 1;
  localparam int PCW = $clog2(PEND_FRAMES + 1);

  // Left/up limits are rearranged as pos <= MIN+SIZE so nothing subtracts below zero.
  localparam logic [W:0]     L_LIM   = WP1'(X_MIN + SIZE);
  localparam logic [W:0]     U_LIM   = WP1'(Y_MIN + SIZE);
  localparam logic [W:0]     R_LIM   = WP1'(X_MAX);
  localparam logic [W:0]     D_LIM   = WP1'(Y_MAX);
  localparam logic [W:0]     SIZE_E  = WP1'(SIZE);
  localparam logic [W-1:0]   STEP_W  = W'(STEP);
  localparam logic [W-1:0]   TY_LO   = W'(TUN_Y_LO);
  localparam logic [W-1:0]   TY_HI   = W'(TUN_Y_HI);
  localparam logic [W-1:0]   TX_LO   = W'(TUN_X_LO);
  localparam logic [W-1:0]   TX_HI   = W'(TUN_X_HI);
  localparam logic [W-1:0]   DEST_L  = W'(TUN_L_DEST);
  localparam logic [W-1:0]   DEST_R  = W'(TUN_R_DEST);
  localparam logic [3:0]     DIV_END = 4'(SPEED_DIV - 1);
  localparam logic [PCW-1:0] PEND_INIT = PCW'(PEND_FRAMES);

  logic [W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  state_t         state_q, state_d;
  dir_t           cur_dir_q, cur_dir_d, last_dir_q, last_dir_d;
  dir_t           pend_dir_q, pend_dir_d;
  logic           pend_valid_q, pend_valid_d;
  logic [PCW-1:0] pend_cnt_q, pend_cnt_d;
  logic [3:0]     div_cnt_q, div_cnt_d;

  logic           key_valid;
  dir_t           key_dir;
  logic [3:0]     blk;
  logic           in_band, tick, do_move, take_pend;
  dir_t           dir_next;
  logic [W:0]     px_e, py_e;

  key_dir_decode u_decode (
    .keycode (keycode),
    .valid   (key_valid),
    .dir     (key_dir)
  );

  always_comb begin
    px_e    = {1'b0, pos_x_q};
    py_e    = {1'b0, pos_y_q};
    in_band = (pos_y_q >= TY_LO) && (pos_y_q <= TY_HI);
    blk     = 4'b0000;
    blk[DIR_UP]    = wall_u | (py_e <= U_LIM);
    blk[DIR_DOWN]  = wall_d | ((py_e + SIZE_E) >= D_LIM);
    blk[DIR_LEFT]  = wall_l | (!in_band && (px_e <= L_LIM));
    blk[DIR_RIGHT] = wall_r | (!in_band && ((px_e + SIZE_E) >= R_LIM));
  end

  always_comb begin
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    state_d      = state_q;
    cur_dir_d    = cur_dir_q;
    last_dir_d   = last_dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    pend_cnt_d   = pend_cnt_q;
    div_cnt_d    = div_cnt_q;
    tick         = (div_cnt_q == DIV_END);
    do_move      = 1'b0;
    take_pend    = 1'b0;
    dir_next     = cur_dir_q;

    if (!freeze) begin
      div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;

      if (tick) begin
        if (pend_valid_q && !blk[pend_dir_q]) begin
          dir_next  = pend_dir_q;
          do_move   = 1'b1;
          take_pend = 1'b1;
        end else if (state_q == ST_MOVING && !blk[cur_dir_q]) begin
          do_move = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      if (do_move) begin
        state_d    = ST_MOVING;
        cur_dir_d  = dir_next;
        last_dir_d = dir_next;
        case (dir_next)
          DIR_UP:    pos_y_d = pos_y_q - STEP_W;
          DIR_DOWN:  pos_y_d = pos_y_q + STEP_W;
          DIR_LEFT:  pos_x_d = (in_band && pos_x_q <= TX_LO) ? DEST_R : pos_x_q - STEP_W;
          DIR_RIGHT: pos_x_d = (in_band && pos_x_q >= TX_HI) ? DEST_L : pos_x_q + STEP_W;
          default:   pos_x_d = pos_x_q;
        endcase
      end

      // A key at this edge overrides consumption/expiry and becomes the new request.
      if (key_valid) begin
        pend_valid_d = 1'b1;
        pend_dir_d   = key_dir;
        pend_cnt_d   = PEND_INIT;
      end else if (take_pend) begin
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        if (pend_cnt_q == '0) pend_valid_d = 1'b0;
        else                  pend_cnt_d   = pend_cnt_q - PCW'(1);
      end
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x_q      <= W'(X_CENTER);
      pos_y_q      <= W'(Y_CENTER);
      state_q      <= ST_IDLE;
      cur_dir_q    <= DIR_UP;
      last_dir_q   <= DIR_UP;
      pend_dir_q   <= DIR_UP;
      pend_valid_q <= 1'b0;
      pend_cnt_q   <= '0;
      div_cnt_q    <= 4'd0;
    end else begin
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      state_q      <= state_d;
      cur_dir_q    <= cur_dir_d;
      last_dir_q   <= last_dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      pend_cnt_q   <= pend_cnt_d;
      div_cnt_q    <= div_cnt_d;
    end
  end

  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign size     = W'(SIZE);
  assign cur_dir  = cur_dir_q;
  assign last_dir = last_dir_q;
  assign moving   = (state_q == ST_MOVING);

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: two instances (SPEED_DIV 1 and 3) driven by shared
// inputs and compared each frame against a rule-level reference model.
module tb_sprite_mover;

  localparam int STEP = 1;
  localparam int SIZE = 13;

  // ---------------- clock / reset ----------------
  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic       Reset_n;
  logic [7:0] keycode;
  logic       freeze, wall_l, wall_r, wall_u, wall_d;

  logic [9:0] px1, py1, sz1, px3, py3, sz3;
  logic [1:0] cd1, ld1, cd3, ld3;
  logic       mv1, mv3;

  sprite_mover u_dut1 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .freeze(freeze),
    .wall_l(wall_l), .wall_r(wall_r), .wall_u(wall_u), .wall_d(wall_d),
    .pos_x(px1), .pos_y(py1), .size(sz1), .cur_dir(cd1), .last_dir(ld1), .moving(mv1)
  );

  sprite_mover #(.SPEED_DIV(3)) u_dut3 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(keycode), .freeze(freeze),
    .wall_l(wall_l), .wall_r(wall_r), .wall_u(wall_u), .wall_d(wall_d),
    .pos_x(px3), .pos_y(py3), .size(sz3), .cur_dir(cd3), .last_dir(ld3), .moving(mv3)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Directions: 0=up 1=down 2=left 3=right.
  typedef struct {
    int x; int y; bit mv; int cur; int last;
    bit pv; int pdir; int pcnt; int div;
  } model_t;

  model_t m[2];
  int     sdiv[2];

  function automatic model_t m_reset();
    model_t s;
    s.x = 202; s.y = 253; s.mv = 0; s.cur = 0; s.last = 0;
    s.pv = 0; s.pdir = 0; s.pcnt = 0; s.div = 0;
    return s;
  endfunction

  function automatic bit in_band(int y);
    return (y >= 195) && (y <= 223);
  endfunction

  function automatic bit m_blocked(model_t s, int d);
    case (d)
      0: return wall_u || (s.y - SIZE <= 0);
      1: return wall_d || (s.y + SIZE >= 447);
      2: return wall_l || (!in_band(s.y) && (s.x - SIZE <= 0));
      default: return wall_r || (!in_band(s.y) && (s.x + SIZE >= 404));
    endcase
  endfunction

  function automatic model_t m_step(model_t s, int sd);
    model_t n;
    bit kv, tick, used;
    int kd, d;
    n = s;
    if (freeze) return s;
    kv = 1; kd = 0;
    case (keycode)
      8'h04: kd = 2;
      8'h07: kd = 3;
      8'h16: kd = 1;
      8'h1A: kd = 0;
      default: kv = 0;
    endcase
    tick  = (s.div == sd - 1);
    n.div = tick ? 0 : s.div + 1;
    used  = 0;
    d     = -1;
    if (tick) begin
      if (s.pv && !m_blocked(s, s.pdir)) begin d = s.pdir; used = 1; end
      else if (s.mv && !m_blocked(s, s.cur)) d = s.cur;
      else n.mv = 0;
    end
    if (d >= 0) begin
      n.mv = 1; n.cur = d; n.last = d;
      case (d)
        0: n.y = s.y - STEP;
        1: n.y = s.y + STEP;
        2: n.x = (in_band(s.y) && s.x <= 10)  ? 385 : s.x - STEP;
        default: n.x = (in_band(s.y) && s.x >= 390) ? 15 : s.x + STEP;
      endcase
    end
    if (kv) begin n.pv = 1; n.pdir = kd; n.pcnt = 16; end
    else if (used) n.pv = 0;
    else if (s.pv) begin
      if (s.pcnt == 0) n.pv = 0;
      else n.pcnt = s.pcnt - 1;
    end
    return n;
  endfunction

  task automatic compare_all();
    check_eq("x1", px1, m[0].x);     check_eq("y1", py1, m[0].y);
    check_eq("mv1", mv1, m[0].mv);   check_eq("cd1", cd1, m[0].cur);
    check_eq("ld1", ld1, m[0].last);
    check_eq("x3", px3, m[1].x);     check_eq("y3", py3, m[1].y);
    check_eq("mv3", mv3, m[1].mv);   check_eq("cd3", cd3, m[1].cur);
    check_eq("ld3", ld3, m[1].last);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge frame_clk);
    for (int i = 0; i < 2; i++) m[i] = m_step(m[i], sdiv[i]);
    #1;
    compare_all();
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    step();
    keycode = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    Reset_n = 1'b0;
    for (int i = 0; i < 2; i++) m[i] = m_reset();
    #1;
    compare_all();
    @(negedge frame_clk);
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int xb, yb, guard, changes, prev, sx1, sx3, r;

  initial begin
    sdiv[0] = 1; sdiv[1] = 3;
    keycode = 8'h00; freeze = 0;
    wall_l = 0; wall_r = 0; wall_u = 0; wall_d = 0;
    Reset_n = 1'b1;
    for (int i = 0; i < 2; i++) m[i] = m_reset();

    // Reset and idle
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check_eq("rst_x", px1, 202); check_eq("rst_y", py1, 253);
    check_eq("rst_mv", mv1, 0);  check_eq("rst_cd", cd1, 0);
    check_eq("rst_ld", ld1, 0);  check_eq("size", sz1, SIZE);

    // One-frame left press: request latency then continuous motion
    press(8'h04);
    check_eq("l_lat_mv", mv1, 0); check_eq("l_lat_x", px1, 202);
    step(); check_eq("l_mv", mv1, 1); check_eq("l_x0", px1, 201);
    step(); check_eq("l_x1", px1, 200);
    step(); check_eq("l_x2", px1, 199);
    wall_l = 1;
    step(); check_eq("wl_x", px1, 199); check_eq("wl_mv", mv1, 0); check_eq("wl_ld", ld1, 2);
    wall_l = 0;

    // Buffered turn released after 5 blocked frames
    press(8'h07);
    for (int i = 0; i < 3; i++) step();
    wall_u = 1; xb = m[0].x; yb = m[0].y;
    press(8'h1A);
    for (int i = 0; i < 4; i++) step();
    check_eq("bt_x", px1, xb + 5); check_eq("bt_y", py1, yb);
    wall_u = 0;
    step(); check_eq("bt_turn_y", py1, yb - 1); check_eq("bt_turn_cd", cd1, 0);
    check_eq("bt_turn_x", px1, xb + 5);

    // Buffered turn expires after 17 blocked frames
    press(8'h07);
    step();
    wall_u = 1; xb = m[0].x; yb = m[0].y;
    press(8'h1A);
    for (int i = 0; i < 17; i++) step();
    wall_u = 0;
    step(); step();
    check_eq("exp_cd", cd1, 3); check_eq("exp_y", py1, yb); check_eq("exp_x", px1, xb + 20);

    // Reset mid-move wins immediately
    @(posedge frame_clk); #3;
    Reset_n = 1'b0;
    for (int i = 0; i < 2; i++) m[i] = m_reset();
    #1;
    check_eq("amid_x", px1, 202); check_eq("amid_mv", mv1, 0);
    @(negedge frame_clk); Reset_n = 1'b1;

    // Tunnel wrap: walk up into the band then left to x=12
    press(8'h1A);
    guard = 0;
    while (m[0].y != 211 && guard < 100) begin step(); guard++; end
    check_eq("tmo_up", guard < 100, 1);
    press(8'h04);
    guard = 0;
    while (m[0].x != 12 && guard < 400) begin step(); guard++; end
    check_eq("tmo_left", guard < 400, 1);
    check_eq("tun_x12", px1, 12);
    step(); check_eq("tun_x11", px1, 11);
    step(); check_eq("tun_x10", px1, 10);
    step(); check_eq("tun_wrap_l", px1, 385);
    press(8'h07);
    guard = 0;
    while (m[0].x != 389 && guard < 50) begin step(); guard++; end
    check_eq("tmo_right", guard < 50, 1);
    step(); check_eq("tun_x390", px1, 390);
    step(); check_eq("tun_wrap_r", px1, 15);

    // Speed divider and freeze
    do_reset();
    press(8'h07);
    changes = 0; prev = 202;
    for (int i = 0; i < 12; i++) begin
      step();
      if (px3 !== prev[9:0]) changes++;
      prev = m[1].x;
    end
    check_eq("div3_moves", changes, 4);
    freeze = 1; sx1 = m[0].x; sx3 = m[1].x;
    for (int i = 0; i < 5; i++) begin
      step(); check_eq("frz_x1", px1, sx1); check_eq("frz_x3", px3, sx3);
    end
    freeze = 0;
    for (int i = 0; i < 6; i++) step();

    // Randomized run against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0: keycode = 8'h04;
        1: keycode = 8'h07;
        2: keycode = 8'h16;
        3: keycode = 8'h1A;
        4: keycode = 8'h55;
        default: keycode = 8'h00;
      endcase
      wall_l = ($urandom_range(0, 3) == 0);
      wall_r = ($urandom_range(0, 3) == 0);
      wall_u = ($urandom_range(0, 3) == 0);
      wall_d = ($urandom_range(0, 3) == 0);
      freeze = ($urandom_range(0, 15) == 0);
      step();
    end
    keycode = 8'h00; freeze = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
